// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stall, branch flush, memory freeze,
// operand forwarding, sticky memory timeout and saturating perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic             load_e,
  input  logic             pc_src_e,
  input  logic [4:0]       rd_m,
  input  logic             reg_write_m,
  input  logic             mem_req_m,
  input  logic             mem_ack,
  input  logic [4:0]       rd_w,
  input  logic             reg_write_w,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_ERR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WW-1:0]    r_wait_cnt;
  logic [WW-1:0]    w_wait_nxt;
  logic [WW-1:0]    w_wait_inc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_lw_stall;
  logic             w_mem_busy;
  logic             w_freeze;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wem,
    input logic [4:0] rdw,
    input logic       wew
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wem && rdm != 5'd0 && rdm == rs)
      sel = 2'b10;
    else if (wew && rdw != 5'd0 && rdw == rs)
      sel = 2'b01;
    return sel;
  endfunction

  assign forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m,
                               rd_w, reg_write_w);
  assign forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m,
                               rd_w, reg_write_w);

  assign w_lw_stall = load_e && rd_e != 5'd0 &&
                      (rd_e == rs1_d || rd_e == rs2_d);
  assign w_mem_busy = mem_req_m && !mem_ack;
  assign w_freeze   = w_mem_busy || r_state == S_ERR;
  assign w_wait_inc = r_wait_cnt + 1'b1;

  // Freeze holds D and E, so deferred stalls/flushes re-resolve later
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (w_freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else begin
      stall_f = w_lw_stall;
      stall_d = w_lw_stall;
      flush_d = pc_src_e;
      flush_e = w_lw_stall || pc_src_e;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_mem_busy) begin
          w_state_nxt = S_WAIT;
          w_wait_nxt  = WW'(1);
        end
      end
      S_WAIT: begin
        if (!w_mem_busy) begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = '0;
        end else if (w_wait_inc == WW'(TIMEOUT)) begin
          w_state_nxt = S_ERR;
        end else begin
          w_wait_nxt  = w_wait_inc;
        end
      end
      S_ERR: w_state_nxt = S_ERR;
      default: begin
        w_state_nxt = S_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_RUN;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (stall_f && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (flush_d && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign mem_timeout = r_state == S_ERR;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (TIMEOUT=4, CNT_W=4): driver queues
// expectations, negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       load_e, pc_src_e, reg_write_m, mem_req_m, mem_ack;
  logic       reg_write_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string      name;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] st;
    logic [2:0] fl;
    logic       to;
    logic [3:0] sc;
    logic [3:0] fc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .load_e(load_e), .pc_src_e(pc_src_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m),
    .mem_req_m(mem_req_m), .mem_ack(mem_ack),
    .rd_w(rd_w), .reg_write_w(reg_write_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: every negedge with a pending expectation is one comparison
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (forward_a_e !== e.fa || forward_b_e !== e.fb ||
          {stall_f, stall_d, stall_e, stall_m} !== e.st ||
          {flush_d, flush_e, flush_w} !== e.fl ||
          mem_timeout !== e.to ||
          stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        bad++;
        $display("FAIL %s: got fa=%b fb=%b st=%b fl=%b to=%b sc=%0d fc=%0d want fa=%b fb=%b st=%b fl=%b to=%b sc=%0d fc=%0d",
                 e.name, forward_a_e, forward_b_e,
                 {stall_f, stall_d, stall_e, stall_m},
                 {flush_d, flush_e, flush_w}, mem_timeout,
                 stall_cnt, flush_cnt,
                 e.fa, e.fb, e.st, e.fl, e.to, e.sc, e.fc);
      end
    end
  end

  task automatic expect_(
    input string      n,
    input logic [1:0] fa,
    input logic [1:0] fb,
    input logic [3:0] st,
    input logic [2:0] fl,
    input logic       to,
    input logic [3:0] sc,
    input logic [3:0] fc
  );
    exp_t e;
    e.name = n;
    e.fa = fa;
    e.fb = fb;
    e.st = st;
    e.fl = fl;
    e.to = to;
    e.sc = sc;
    e.fc = fc;
    q.push_back(e);
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    load_e = 0; pc_src_e = 0;
    reg_write_m = 0; reg_write_w = 0;
    mem_req_m = 0; mem_ack = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    expect_("reset", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Forwarding
    rd_m = 5; reg_write_m = 1; rd_w = 5; reg_write_w = 1; rs1_e = 5;
    expect_("fwd_m", 2'b10, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    rd_m = 6;
    expect_("fwd_w", 2'b01, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    rs1_e = 0; rd_m = 0; rd_w = 0;
    expect_("fwd_none", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    rs2_e = 6; rd_m = 6; reg_write_m = 0; rd_w = 6; reg_write_w = 1;
    expect_("fwd_b_w", 2'b00, 2'b01, 4'b0000, 3'b000, 0, 0, 0);
    tick();

    // Load-use
    idle();
    load_e = 1; rd_e = 7; rs2_d = 7;
    expect_("lw_stall", 2'b00, 2'b00, 4'b1100, 3'b010, 0, 0, 0);
    tick();
    rd_e = 0; rs2_d = 0;
    expect_("lw_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 1, 0);
    tick();

    // Branch together with load-use
    do_reset();
    load_e = 1; rd_e = 3; rs1_d = 3; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      expect_("br_lw", 2'b00, 2'b00, 4'b1100, 3'b110, 0,
              4'(i), 4'(i));
      tick();
    end
    idle();
    expect_("br_lw_cnt", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 3, 3);
    tick();

    // Memory wait with pending branch, acked on 4th cycle
    do_reset();
    mem_req_m = 1; pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      expect_("mem_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 0,
              4'(i), 0);
      tick();
    end
    mem_ack = 1;
    expect_("mem_ack_br", 2'b00, 2'b00, 4'b0000, 3'b110, 0, 3, 0);
    tick();
    idle();
    expect_("mem_run", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 3, 1);
    tick();
    mem_req_m = 1;
    expect_("busy_1", 2'b00, 2'b00, 4'b1111, 3'b001, 0, 3, 1);
    tick();
    mem_ack = 1;
    expect_("busy_ack", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 4, 1);
    tick();
    idle();
    expect_("busy_done", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 4, 1);
    tick();

    // Timeout into ERR
    do_reset();
    mem_req_m = 1;
    for (int i = 0; i < 4; i++) begin
      expect_("to_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 0,
              4'(i), 0);
      tick();
    end
    expect_("to_err", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 4, 0);
    tick();
    mem_ack = 1; pc_src_e = 1;
    expect_("err_sticky", 2'b00, 2'b00, 4'b1111, 3'b001, 1, 5, 0);
    tick();
    idle();
    rst_n = 1'b0;
    expect_("err_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    expect_("post_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 0, 0);
    tick();

    // Saturation
    do_reset();
    load_e = 1; rd_e = 9; rs2_d = 9; pc_src_e = 1;
    for (int i = 0; i < 20; i++) begin
      expect_("sat", 2'b00, 2'b00, 4'b1100, 3'b110, 0,
              4'(i > 15 ? 15 : i), 4'(i > 15 ? 15 : i));
      tick();
    end
    idle();
    expect_("sat_hold", 2'b00, 2'b00, 4'b0000, 3'b000, 0, 15, 15);
    tick();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
